sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single pipelined ZBT SRAM (20-bit word address, 32-bit data) between two requesters.
  - Port A: CPU load/store unit, high priority.
  - Port B: I/O-side requester (RS-232C instruction loader, SD/keyboard buffers), low priority.
- Issues at most one SRAM command per cycle.
- Tracks in-flight commands in a tag pipeline so read data returns to the port that issued the read, and write data is driven in the correct bus cycle.
- Sits between the requesters and the top-level ZD/ZA pin logic.

Parameters:
- READ_LAT, 4: cycles from the accept edge to the rvalid edge. Covers the output register, 2-cycle ZBT pipeline and input capture register.
- WR_LAT, 2: cycles from the address cycle to the cycle zd_oe/zd_out carry the write data.
- STARVE_LIMIT, 8: number of consecutive cycles B may be refused while requesting before B is forced a grant.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  A command request
- a_we  in  1  A write (1) / read (0)
- a_addr  in  20  A word address
- a_wdata  in  32  A write data
- a_be  in  4  A byte enables, active-high
- a_ready  out  1  combinational; A command accepted at this edge
- a_rvalid  out  1  A read data valid, one-cycle pulse
- a_rdata  out  32  A read data
- b_req, b_we, b_addr, b_wdata, b_be, b_ready, b_rvalid, b_rdata  same as the A signals, for port B
- sram_za  out  20  registered address to ZA
- sram_xwa  out  1  registered write strobe, active-low
- sram_xzbe  out  4  registered byte enables, active-low
- sram_zd_out  out  32  write data to ZD
- sram_zd_oe  out  1  drive enable for ZD; the top level tristates ZD when 0
- sram_zd_in  in  32  ZD sampled from the pins

Behaviour:
- **Reset values:** sram_za=0, sram_xwa=1, sram_xzbe=4'hF, sram_zd_oe=0, sram_zd_out=0, a/b_rvalid=0, a/b_rdata=0, starve counter=0, tag pipeline all IDLE.
- **Arbitration** (combinational, every cycle):
  - grant_b = b_req & (~a_req | starve_cnt==STARVE_LIMIT); grant_a = a_req & ~grant_b.
  - a_ready=grant_a, b_ready=grant_b; at most one is high.
  - A requester holds req and its fields stable until it sees ready at a rising edge.
- **Starve counter:**
  - Increments when b_req & ~b_ready, saturating at STARVE_LIMIT.
  - Clears on b_ready or when ~b_req.
  - When forced, A gets ready=0 that cycle and is accepted the next cycle (A waits at most 1 cycle).
- **Command issue** (on the accept edge):
  - sram_za <= granted addr.
  - sram_xwa <= ~we.
  - sram_xzbe <= we ? ~be : 4'h0.
- **Idle cycle** (no grant): sram_xwa=1, sram_xzbe=4'hF, sram_za holds its value. This is a harmless read NOP and carries no tag.
- **Tag pipeline:**
  - Depth READ_LAT shift register of {valid, port, we, wdata}; entry pushed on the accept edge.
  - Write entry at stage WR_LAT: sram_zd_oe=1 and sram_zd_out=wdata for exactly one cycle.
  - Read entry: sram_zd_in is captured, then at stage READ_LAT the owning port's rvalid pulses for one cycle with rdata = captured word.
  - The non-owning port's rvalid stays 0; its rdata holds its last value.
- **Throughput:** back-to-back mixed reads and writes from either port at one per cycle. No turnaround bubbles, because ZBT has no dead cycle.
- **Ordering:** per-port results return in issue order, since latency is fixed.
- **Simultaneous events:**
  - A write issued at cycle N and a read at N+1 are legal.
  - sram_zd_oe is never high in a cycle whose stage-WR_LAT entry is a read.
- **Reset mid-operation:**
  - All in-flight tags are discarded.
  - sram_zd_oe drops immediately (asynchronous).
  - No rvalid for commands accepted before reset.

Decomposition:
- Shared package/header `sram_defs`:
  - SRAM_AW=20, SRAM_DW=32, SRAM_BW=4.
  - PORT_A=1'b0, PORT_B=1'b1.
  - Tag field widths.
- One sub-module, `sram_tag_pipe`: parameterised-depth shift register of tags, exposing the stage-WR_LAT and stage-READ_LAT taps.
- Arbitration and the starve counter stay in `sram_arbiter`.

Test Plan:
- **Single read:** A read addr 20'h00010, fake SRAM preloaded 32'hDEADBEEF → a_ready that cycle; a_rvalid exactly 4 cycles later with a_rdata=32'hDEADBEEF; b_rvalid stays 0.
- **Write then read-back:** B write 20'h00020 data 32'h12345678 be=4'hF, then B read same addr next cycle → sram_zd_oe high only in the write's stage-2 cycle; b_rdata=32'h12345678.
- **Byte enables:** A write be=4'b0010 data 32'hAABBCCDD over 32'h00000000 → sram_xzbe=4'b1101; read returns 32'h0000CC00.
- **Starvation:**
  - Stimulus: a_req held high continuously, b_req high from cycle 0.
  - b_ready first asserts at cycle 8 (starve counter reaches 8); a_ready=0 in that cycle only; counter returns to 0.
- **Interleaved stream:**
  - Stimulus: 16 alternating A reads and B reads, one per cycle.
  - 16 rvalid pulses, each on the correct port, in issue order, each 4 cycles after its accept edge.
- **Reset mid-flight:**
  - Stimulus: assert reset 2 cycles after a read accept and a write accept.
  - Outputs return to reset values asynchronously; no rvalid; sram_zd_oe=0; commands accepted after reset release complete normally.

Source files
------------

// File: rtl/sram_defs.sv
// Shared widths, port ids and the in-flight tag format for the ZBT SRAM arbiter.
package sram_defs;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 32;
  localparam int SRAM_BW = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic               valid;
    logic               port;
    logic               we;
    logic [SRAM_DW-1:0] wdata;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_A, we: 1'b0, wdata: '0};

  // ZBT byte-write strobes are active-low; reads enable every lane.
  function automatic logic [SRAM_BW-1:0] zbe_of(input logic we, input logic [SRAM_BW-1:0] be);
    return we ? ~be : '0;
  endfunction

endpackage

// File: rtl/sram_tag_pipe.sv
// Fixed-depth shift register of in-flight command tags, one push per cycle, no stall.
// Exposes the write-data tap (stage WR_TAP) and the read-return tap (last stage).
module sram_tag_pipe
  import sram_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int WR_TAP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  tag_t               push,
  output logic               wr_vld,
  output logic [SRAM_DW-1:0] wr_dat,
  output logic               rd_vld,
  output logic               rd_port
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_IDLE;
      end
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign wr_vld  = stage[WR_TAP-1].valid & stage[WR_TAP-1].we;
  assign wr_dat  = stage[WR_TAP-1].wdata;
  assign rd_vld  = stage[DEPTH-1].valid & ~stage[DEPTH-1].we;
  assign rd_port = stage[DEPTH-1].port;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port front end for a pipelined ZBT SRAM: A has priority, B is force-granted after STARVE_LIMIT refusals.
// Ready is combinational (one command per cycle); read data returns READ_LAT cycles after accept, write data WR_LAT after the address cycle.
module sram_arbiter
  import sram_defs::*;
#(
  parameter int READ_LAT     = 4,
  parameter int WR_LAT       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [SRAM_AW-1:0] a_addr,
  input  logic [SRAM_DW-1:0] a_wdata,
  input  logic [SRAM_BW-1:0] a_be,
  output logic               a_ready,
  output logic               a_rvalid,
  output logic [SRAM_DW-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [SRAM_AW-1:0] b_addr,
  input  logic [SRAM_DW-1:0] b_wdata,
  input  logic [SRAM_BW-1:0] b_be,
  output logic               b_ready,
  output logic               b_rvalid,
  output logic [SRAM_DW-1:0] b_rdata,
  output logic [SRAM_AW-1:0] sram_za,
  output logic               sram_xwa,
  output logic [SRAM_BW-1:0] sram_xzbe,
  output logic [SRAM_DW-1:0] sram_zd_out,
  output logic               sram_zd_oe,
  input  logic [SRAM_DW-1:0] sram_zd_in
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   starve_cnt;
  logic               grant_a;
  logic               grant_b;
  tag_t               push;
  logic               wr_vld;
  logic [SRAM_DW-1:0] wr_dat;
  logic               rd_vld;
  logic               rd_port;
  logic [SRAM_DW-1:0] zd_cap;

  always_comb begin
    grant_b = b_req & (~a_req | (starve_cnt == CNT_MAX));
    grant_a = a_req & ~grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Counts consecutive refused cycles of a pending B request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!b_req || grant_b) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_za   <= '0;
      sram_xwa  <= 1'b1;
      sram_xzbe <= '1;
    end else if (grant_a) begin
      sram_za   <= a_addr;
      sram_xwa  <= ~a_we;
      sram_xzbe <= zbe_of(a_we, a_be);
    end else if (grant_b) begin
      sram_za   <= b_addr;
      sram_xwa  <= ~b_we;
      sram_xzbe <= zbe_of(b_we, b_be);
    end else begin
      // Idle: a read NOP with all lanes masked; address is left alone.
      sram_xwa  <= 1'b1;
      sram_xzbe <= '1;
    end
  end

  always_comb begin
    push = TAG_IDLE;
    if (grant_a) begin
      push = '{valid: 1'b1, port: PORT_A, we: a_we, wdata: a_wdata};
    end else if (grant_b) begin
      push = '{valid: 1'b1, port: PORT_B, we: b_we, wdata: b_wdata};
    end
  end

  sram_tag_pipe #(
    .DEPTH  (READ_LAT),
    .WR_TAP (WR_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_vld  (wr_vld),
    .wr_dat  (wr_dat),
    .rd_vld  (rd_vld),
    .rd_port (rd_port)
  );

  // zd_cap samples the pins every edge; the read tap picks up the word captured one edge earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_zd_oe  <= 1'b0;
      sram_zd_out <= '0;
      zd_cap      <= '0;
      a_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rvalid    <= 1'b0;
      b_rdata     <= '0;
    end else begin
      sram_zd_oe <= wr_vld;
      if (wr_vld) begin
        sram_zd_out <= wr_dat;
      end
      zd_cap   <= sram_zd_in;
      a_rvalid <= rd_vld & (rd_port == PORT_A);
      b_rvalid <= rd_vld & (rd_port == PORT_B);
      if (rd_vld && rd_port == PORT_A) begin
        a_rdata <= zd_cap;
      end
      if (rd_vld && rd_port == PORT_B) begin
        b_rdata <= zd_cap;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural ZBT SRAM and an in-order read scoreboard.
module tb_sram_arbiter;
  import sram_defs::*;

  localparam int READ_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_ready, a_rvalid;
  logic [19:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_req, b_we, b_ready, b_rvalid;
  logic [19:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [19:0] sram_za;
  logic        sram_xwa;
  logic [3:0]  sram_xzbe;
  logic [31:0] sram_zd_out;
  logic        sram_zd_oe;
  logic [31:0] sram_zd_in;

  sram_arbiter #(.READ_LAT(4), .WR_LAT(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_za(sram_za), .sram_xwa(sram_xwa), .sram_xzbe(sram_xzbe),
    .sram_zd_out(sram_zd_out), .sram_zd_oe(sram_zd_oe), .sram_zd_in(sram_zd_in)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int a_pulses   = 0;
  int b_pulses   = 0;
  int oe_cycles  = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural ZBT: command sampled at the edge after issue, data two cycles after that.
  logic [19:0] c1_addr, c2_addr;
  logic        c1_we, c2_we;
  logic [3:0]  c1_zbe, c2_zbe;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_addr <= '0; c1_we <= 1'b0; c1_zbe <= '1;
      c2_addr <= '0; c2_we <= 1'b0; c2_zbe <= '1;
    end else begin
      c1_addr <= sram_za; c1_we <= ~sram_xwa; c1_zbe <= sram_xzbe;
      c2_addr <= c1_addr; c2_we <= c1_we;     c2_zbe <= c1_zbe;
    end
  end

  assign sram_zd_in = c2_we ? 32'h0 : mem[c2_addr[7:0]];

  always @(negedge clk) begin
    if (!reset) begin
      check("zd_oe_matches_data_cycle", sram_zd_oe, c2_we);
      if (sram_zd_oe) oe_cycles++;
      if (c2_we) begin
        for (int i = 0; i < 4; i++) begin
          if (!c2_zbe[i]) mem[c2_addr[7:0]][8*i +: 8] <= sram_zd_out[8*i +: 8];
        end
      end
    end
  end

  task automatic accept(input logic port, input logic we, input logic [19:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ref_mem[addr[7:0]][8*i +: 8] = wdata[8*i +: 8];
      end
    end else begin
      e.port = port;
      e.data = ref_mem[addr[7:0]];
      e.due  = cyc + 1 + READ_LAT;
      sb.push_back(e);
    end
  endtask

  task automatic got(input logic port, input logic [31:0] data);
    exp_t e;
    if (port == PORT_A) a_pulses++; else b_pulses++;
    check("rvalid_has_pending_read", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rvalid_port", port, e.port);
      check("rdata", data, e.data);
      check("rvalid_cycle", cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("single_grant", a_ready & b_ready, 1'b0);
      if (a_req && a_ready) accept(PORT_A, a_we, a_addr, a_wdata, a_be);
      if (b_req && b_ready) accept(PORT_B, b_we, b_addr, b_wdata, b_be);
      if (a_rvalid) got(PORT_A, a_rdata);
      if (b_rvalid) got(PORT_B, b_rdata);
    end
  end

  // Called just after a rising edge; returns just after the accept edge with req dropped.
  task automatic issue(input logic port, input logic we, input logic [19:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int   n;
    logic rdy;
    if (port == PORT_A) begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
    end else begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = (port == PORT_A) ? a_ready : b_ready;
      n++;
    end while (!rdy && n < 20);
    check("ready_wait_cycles", n, 1);
    @(posedge clk); #1;
    if (port == PORT_A) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string ctx);
    check({ctx, "_za"}, sram_za, 20'h0);
    check({ctx, "_xwa"}, sram_xwa, 1'b1);
    check({ctx, "_xzbe"}, sram_xzbe, 4'hF);
    check({ctx, "_zd_oe"}, sram_zd_oe, 1'b0);
    check({ctx, "_zd_out"}, sram_zd_out, 32'h0);
    check({ctx, "_a_rvalid"}, a_rvalid, 1'b0);
    check({ctx, "_b_rvalid"}, b_rvalid, 1'b0);
    check({ctx, "_a_rdata"}, a_rdata, 32'h0);
    check({ctx, "_b_rdata"}, b_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pa, pb, po;
    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h0;        ref_mem[8'h30] = 32'h0;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_a_ready_idle", a_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single A read
    issue(PORT_A, 1'b0, 20'h00010, 32'h0, 4'h0);
    drain();
    check("single_read_a_rdata", a_rdata, 32'hDEADBEEF);
    check("single_read_a_pulses", a_pulses, 1);
    check("single_read_b_pulses", b_pulses, 0);

    // B write then immediate read-back
    po = oe_cycles;
    issue(PORT_B, 1'b1, 20'h00020, 32'h12345678, 4'hF);
    issue(PORT_B, 1'b0, 20'h00020, 32'h0, 4'h0);
    drain();
    check("wr_rd_b_rdata", b_rdata, 32'h12345678);
    check("wr_rd_oe_cycles", oe_cycles - po, 1);

    // Partial byte write over a zero word
    issue(PORT_A, 1'b1, 20'h00030, 32'hAABBCCDD, 4'b0010);
    check("be_xzbe", sram_xzbe, 4'b1101);
    check("be_xwa", sram_xwa, 1'b0);
    check("be_za", sram_za, 20'h00030);
    issue(PORT_A, 1'b0, 20'h00030, 32'h0, 4'h0);
    check("be_read_xzbe", sram_xzbe, 4'h0);
    drain();
    check("be_a_rdata", a_rdata, 32'h0000CC00);

    // Starvation: A saturates the bus, B forced through every ninth cycle
    a_we = 1'b0; a_addr = 20'h00040; a_req = 1'b1;
    b_we = 1'b0; b_addr = 20'h00041; b_req = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check($sformatf("starve_a_ready_k%0d", k), a_ready, (k != 8 && k != 17));
      check($sformatf("starve_b_ready_k%0d", k), b_ready, (k == 8 || k == 17));
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    drain();
    check("starve_b_rdata", b_rdata, 32'hC0DE_0041);

    // Interleaved A/B reads at one per cycle
    pa = a_pulses; pb = b_pulses;
    for (int i = 0; i < 16; i++) begin
      issue((i % 2 == 0) ? PORT_A : PORT_B, 1'b0, 20'h00050 + 20'(i), 32'h0, 4'h0);
    end
    drain();
    check("stream_a_pulses", a_pulses - pa, 8);
    check("stream_b_pulses", b_pulses - pb, 8);

    // Reset while a read and a write are in flight
    issue(PORT_A, 1'b0, 20'h00060, 32'h0, 4'h0);
    issue(PORT_B, 1'b1, 20'h00061, 32'h55AA55AA, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_zd_oe", sram_zd_oe, 1'b1);
    check("pre_reset_zd_out", sram_zd_out, 32'h55AA55AA);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    pa = a_pulses; pb = b_pulses;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_no_a_rvalid", a_pulses - pa, 0);
    check("post_reset_no_b_rvalid", b_pulses - pb, 0);
    issue(PORT_A, 1'b0, 20'h00062, 32'h0, 4'h0);
    drain();
    check("post_reset_a_rdata", a_rdata, 32'hC0DE_0062);
    check("post_reset_b_rdata_held", b_rdata, 32'h0);

    check("final_scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
